seg_scan_driver: RTL and testbench
==================================

// Module: seg_scan_driver
// PURPOSE
//   Display end of the traffic-light countdown path: takes the two 2-digit BCD
//   counts (cnt_for_TT, cnt_for_RC) and time-multiplexes them onto a 4-digit
//   7-segment display, one digit per scan slot.
//   Inputs are snapshotted once per frame so a displayed frame never mixes old
//   and new counts.
// PARAMETERS
//   SCAN_DIV     16'd100  clk cycles per digit slot (1 ms @ 100 kHz); legal >= 2
//   COMMON_ANODE 1'b0     0: seg/dig_sel active-high; 1: both active-low
//   BLANK_LZ     1'b1     1: blank a tens digit whose nibble is 0
// PORTS
//   clk         input   1  system clock, 100 kHz
//   rst_n       input   1  asynchronous reset, active-low
//   ena_n       input   1  enable, active-low
//   cnt_for_TT  input   8  BCD count for TT: [7:4] tens, [3:0] units
//   cnt_for_RC  input   8  BCD count for RC: [7:4] tens, [3:0] units
//   seg         output  7  segments {g,f,e,d,c,b,a}
//   dp          output  1  decimal point, always driven "off"
//   dig_sel     output  4  digit enables, one-hot when lit; bit n selects digit n
//   frame_done  output  1  one-clk pulse when a new frame (snapshot) starts
// BEHAVIOUR
//   "On" and "off" below are logical values. All outputs are XORed with
//   COMMON_ANODE at the registers.
//   Reset (rst_n=0, async):
//   - prescaler=0, idx=3, snapshots=8'h00
//   - seg=off, dig_sel=all off, dp=off, frame_done=0
//   Prescaler:
//   - With ena_n=0, counts 0..SCAN_DIV-1 and wraps.
//   - tick = (prescaler==SCAN_DIV-1) && !ena_n
//   On tick:
//   - idx <= idx+1 (mod 4).
//   - If idx==3, snap_TT <= cnt_for_TT, snap_RC <= cnt_for_RC, and
//     frame_done <= 1. Otherwise frame_done <= 0.
//   - The first tick after reset therefore snapshots and shows digit 0.
//   Digit mapping:
//   - 0 = snap_TT[3:0], 1 = snap_TT[7:4], 2 = snap_RC[3:0], 3 = snap_RC[7:4]
//   Output latency:
//   - seg and dig_sel are registered and update in the clk after tick, from the
//     new idx.
//   - They hold constant for SCAN_DIV cycles.
//   - frame_done is high for exactly that first cycle of digit 0.
//   Decode:
//   - Nibbles 0-9 use the standard pattern. 0=7'h3F, 1=7'h06, 8=7'h7F, 9=7'h6F.
//   - Nibbles A-F (invalid BCD) show '-' (7'h40) and are never blanked.
//   Blanking:
//   - If BLANK_LZ=1 and a tens nibble (digits 1, 3) is 0, then seg=off but
//     dig_sel is still asserted.
//   - Units digits are never blanked.
//   ena_n=1 (checked every clk, synchronous):
//   - prescaler<=0, idx<=3, seg<=off, dig_sel<=off, frame_done<=0
//   - Snapshots are held.
//   - On return to ena_n=0, the first tick comes SCAN_DIV cycles later and
//     starts a fresh frame at digit 0.
//   Input changes mid-frame:
//   - Invisible until the next idx 3->0 tick.
//   - Inputs sampled on the same edge as that tick are the ones captured.
//   Reset mid-frame:
//   - Blanks immediately (async).
//   - Restart is identical to power-up.
//   dig_sel is never multi-hot. Between slots it switches in a single clk.
// TESTING (SCAN_DIV=4 unless noted)
//   1. Reset, ena_n=0, TT=8'h25, RC=8'h07, BLANK_LZ=1:
//      - dig_sel sequence 0001,0010,0100,1000, each held 4 clk
//      - seg = 7'h6D ('5'), 7'h5B ('2'), 7'h07 ('7'), blank
//      - frame_done pulses every 16 clk
//   2. Change TT from 8'h25 to 8'h19 while digit 1 is shown:
//      - the rest of that frame still shows 5/2
//      - the next frame shows 9/1
//   3. RC=8'h3C:
//      - digit 2 shows 7'h40 ('-'), digit 3 shows 7'h4F ('3')
//      - with RC=8'h00, digit 2 = 7'h3F, digit 3 blank; BLANK_LZ=0 -> 7'h3F
//   4. Raise ena_n mid-frame for 10 clk:
//      - next clk: dig_sel=0, seg=off
//      - after release, 4 clk dark, then digit 0 with a frame_done pulse
//   5. Assert rst_n=0 asynchronously between clk edges while digit 2 is shown:
//      - outputs go off immediately
//      - after release, the first lit digit is 0 at clk 5
//   6. COMMON_ANODE=1, TT=8'h88:
//      - seg=7'h00 on digits 0-1
//      - dig_sel=1110/1101
//      - idle/reset values: seg=7'h7F, dig_sel=4'hF

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans two 2-digit BCD counts onto a 4-digit multiplexed
// 7-segment display. The counts are snapshotted at the start of every frame
// so one frame never shows a mix of old and new values. All outputs are
// stored in their physical polarity (logical value XOR COMMON_ANODE).
module seg_scan_driver #(
    parameter logic [15:0] SCAN_DIV     = 16'd100,
    parameter logic        COMMON_ANODE = 1'b0,
    parameter logic        BLANK_LZ     = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_n,
    input  logic [7:0] cnt_for_TT,
    input  logic [7:0] cnt_for_RC,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] dig_sel,
    output logic       frame_done
);

    localparam logic [6:0] SEG_OFF = {7{COMMON_ANODE}};
    localparam logic [3:0] DIG_OFF = {4{COMMON_ANODE}};

    // BCD nibble to logical segment pattern {g,f,e,d,c,b,a}; non-BCD shows '-'
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'd0:    pat = 7'h3F;
            4'd1:    pat = 7'h06;
            4'd2:    pat = 7'h5B;
            4'd3:    pat = 7'h4F;
            4'd4:    pat = 7'h66;
            4'd5:    pat = 7'h6D;
            4'd6:    pat = 7'h7D;
            4'd7:    pat = 7'h07;
            4'd8:    pat = 7'h7F;
            4'd9:    pat = 7'h6F;
            default: pat = 7'h40;
        endcase
        return pat;
    endfunction

    logic [15:0] prescaler;
    logic [1:0]  idx;
    logic [7:0]  snap_tt;
    logic [7:0]  snap_rc;

    logic        tick;
    logic [1:0]  idx_nxt;
    logic [7:0]  src_tt;
    logic [7:0]  src_rc;
    logic [3:0]  nib_p0;
    logic [6:0]  seg_p0;
    logic [3:0]  dig_p0;

    // The decimal point is never used; hold it at its physical "off" level.
    assign dp = COMMON_ANODE;

    // Stage 0: pick the digit for the next slot and decode it. On the frame
    // boundary the live inputs are used, since they are what gets snapshotted.
    always_comb begin
        tick    = (prescaler == (SCAN_DIV - 16'd1)) && !ena_n;
        idx_nxt = idx + 2'd1;
        src_tt  = (idx == 2'd3) ? cnt_for_TT : snap_tt;
        src_rc  = (idx == 2'd3) ? cnt_for_RC : snap_rc;
        nib_p0  = src_tt[3:0];
        case (idx_nxt)
            2'd0:    nib_p0 = src_tt[3:0];
            2'd1:    nib_p0 = src_tt[7:4];
            2'd2:    nib_p0 = src_rc[3:0];
            default: nib_p0 = src_rc[7:4];
        endcase
        seg_p0 = bcd_to_seg(nib_p0);
        // Odd slots are tens digits; a zero tens digit is blanked but stays selected.
        if (BLANK_LZ && idx_nxt[0] && (nib_p0 == 4'd0)) begin
            seg_p0 = 7'h00;
        end
        dig_p0 = 4'b0001 << idx_nxt;
    end

    // Stage 1: prescaler, slot index, frame snapshot and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= 16'd0;
            idx        <= 2'd3;
            snap_tt    <= 8'h00;
            snap_rc    <= 8'h00;
            seg        <= SEG_OFF;
            dig_sel    <= DIG_OFF;
            frame_done <= COMMON_ANODE;
        end else if (ena_n) begin
            prescaler  <= 16'd0;
            idx        <= 2'd3;
            seg        <= SEG_OFF;
            dig_sel    <= DIG_OFF;
            frame_done <= COMMON_ANODE;
        end else begin
            frame_done <= COMMON_ANODE;
            if (tick) begin
                prescaler <= 16'd0;
                idx       <= idx_nxt;
                seg       <= seg_p0 ^ SEG_OFF;
                dig_sel   <= dig_p0 ^ DIG_OFF;
                if (idx == 2'd3) begin
                    snap_tt    <= cnt_for_TT;
                    snap_rc    <= cnt_for_RC;
                    frame_done <= !COMMON_ANODE;
                end
            end else begin
                prescaler <= prescaler + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (SCAN_DIV=4). Two instances share the
// stimulus: "a" is common-cathode with leading-zero blanking, "b" is
// common-anode without blanking. Expected output events (every change of the
// displayed tuple) are queued up front; a monitor pops one per change.
module tb_seg_scan_driver;

    typedef struct {
        logic [3:0] d;
        logic [6:0] s;
        logic       f;
        logic       p;
        int         h;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena_n = 1'b0;
    logic [7:0] cnt_tt = 8'h25;
    logic [7:0] cnt_rc = 8'h07;

    logic [6:0] seg_a, seg_b;
    logic [3:0] dig_a, dig_b;
    logic       dp_a, dp_b, fd_a, fd_b;

    exp_t qa[$];
    exp_t qb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.SCAN_DIV(16'd4), .COMMON_ANODE(1'b0), .BLANK_LZ(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .ena_n(ena_n), .cnt_for_TT(cnt_tt), .cnt_for_RC(cnt_rc),
        .seg(seg_a), .dp(dp_a), .dig_sel(dig_a), .frame_done(fd_a));

    seg_scan_driver #(.SCAN_DIV(16'd4), .COMMON_ANODE(1'b1), .BLANK_LZ(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .ena_n(ena_n), .cnt_for_TT(cnt_tt), .cnt_for_RC(cnt_rc),
        .seg(seg_b), .dp(dp_b), .dig_sel(dig_b), .frame_done(fd_b));

    // Logical expectation for both instances; b is stored in physical (inverted) form.
    task automatic ev(input logic [3:0] d, input logic [6:0] sa, input logic [6:0] sb,
                      input logic f, input int h);
        exp_t e;
        e.d = d;  e.s = sa;  e.f = f;  e.p = 1'b0; e.h = h;
        qa.push_back(e);
        e.d = ~d; e.s = ~sb; e.f = ~f; e.p = 1'b1; e.h = h;
        qb.push_back(e);
    endtask

    // One complete frame: digit 0 with frame_done, its drop, then digits 1..3.
    task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                         input logic [6:0] s3a, input logic [6:0] s3b, input int h0);
        ev(4'b0001, s0, s0, 1'b1, h0);
        ev(4'b0001, s0, s0, 1'b0, 1);
        ev(4'b0010, s1, s1, 1'b0, 3);
        ev(4'b0100, s2, s2, 1'b0, 4);
        ev(4'b1000, s3a, s3b, 1'b0, 4);
    endtask

    task automatic wait_enter(input logic [3:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (dig_a == d && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (dig_a != d && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL wait_dig_%b: dig_sel=%b after %0d clk, wanted %b", d, dig_a, n, d);
        end
    endtask

    // Monitor: every change of the displayed tuple is one DUT event to score.
    logic [11:0] prev;
    logic        seen = 1'b0;
    int          cyc = 0;
    int          evn = 0;
    exp_t        ea, eb;
    always @(negedge clk) begin
        cyc++;
        if (!seen || {dig_a, seg_a, fd_a} != prev) begin
            tests += 2;
            if (qa.size() == 0 || qb.size() == 0) begin
                fails += 2;
                $display("FAIL evt%0d_unexpected: dig=%b seg=%h fd=%b, want no further event",
                         evn, dig_a, seg_a, fd_a);
            end else begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                if (dig_a !== ea.d || seg_a !== ea.s || fd_a !== ea.f || dp_a !== ea.p ||
                    (ea.h >= 0 && cyc != ea.h)) begin
                    fails++;
                    $display("FAIL evt%0d_a: got dig=%b seg=%h fd=%b dp=%b hold=%0d, want dig=%b seg=%h fd=%b dp=%b hold=%0d",
                             evn, dig_a, seg_a, fd_a, dp_a, cyc, ea.d, ea.s, ea.f, ea.p, ea.h);
                end
                if (dig_b !== eb.d || seg_b !== eb.s || fd_b !== eb.f || dp_b !== eb.p ||
                    (eb.h >= 0 && cyc != eb.h)) begin
                    fails++;
                    $display("FAIL evt%0d_b: got dig=%b seg=%h fd=%b dp=%b hold=%0d, want dig=%b seg=%h fd=%b dp=%b hold=%0d",
                             evn, dig_b, seg_b, fd_b, dp_b, cyc, eb.d, eb.s, eb.f, eb.p, eb.h);
                end
            end
            prev = {dig_a, seg_a, fd_a};
            seen = 1'b1;
            cyc  = 0;
            evn++;
        end
    end

    initial begin
        // Expected event script
        ev(4'b0000, 7'h00, 7'h00, 1'b0, -1);                 // reset state
        frame(7'h6D, 7'h5B, 7'h07, 7'h00, 7'h3F, -1);        // F1 TT=25 RC=07
        frame(7'h6D, 7'h5B, 7'h07, 7'h00, 7'h3F, 4);         // F2
        frame(7'h6D, 7'h5B, 7'h07, 7'h00, 7'h3F, 4);         // F3 (TT changes mid-frame)
        frame(7'h6F, 7'h06, 7'h07, 7'h00, 7'h3F, 4);         // F4 TT=19
        frame(7'h6F, 7'h06, 7'h40, 7'h4F, 7'h4F, 4);         // F5 RC=3C
        ev(4'b0001, 7'h6F, 7'h6F, 1'b1, 4);                  // F6 RC=00, cut by ena_n
        ev(4'b0001, 7'h6F, 7'h6F, 1'b0, 1);
        ev(4'b0010, 7'h06, 7'h06, 1'b0, 3);
        ev(4'b0100, 7'h3F, 7'h3F, 1'b0, 4);
        ev(4'b0000, 7'h00, 7'h00, 1'b0, 1);                  // dark while disabled
        frame(7'h6F, 7'h06, 7'h3F, 7'h00, 7'h3F, 13);        // F7 after release
        ev(4'b0001, 7'h6F, 7'h6F, 1'b1, 4);                  // F8, cut by reset pulse
        ev(4'b0001, 7'h6F, 7'h6F, 1'b0, 1);
        ev(4'b0010, 7'h06, 7'h06, 1'b0, 3);
        ev(4'b0100, 7'h3F, 7'h3F, 1'b0, 4);
        ev(4'b0000, 7'h00, 7'h00, 1'b0, 1);                  // async blank
        frame(7'h6F, 7'h06, 7'h3F, 7'h00, 7'h3F, 4);         // F9 restart
        frame(7'h7F, 7'h7F, 7'h3F, 7'h00, 7'h3F, 4);         // F10 TT=88
        ev(4'b0000, 7'h00, 7'h00, 1'b0, 1);                  // idle

        // Stimulus
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        wait_enter(4'b0010);                 // F1 digit 1
        wait_enter(4'b0010);                 // F2 digit 1
        wait_enter(4'b0010);                 // F3 digit 1
        cnt_tt = 8'h19;
        wait_enter(4'b0010);                 // F4 digit 1
        cnt_rc = 8'h3C;
        wait_enter(4'b0010);                 // F5 digit 1
        cnt_rc = 8'h00;
        wait_enter(4'b0010);                 // F6 digit 1
        wait_enter(4'b0100);                 // F6 digit 2
        ena_n = 1'b1;
        repeat (10) @(negedge clk);
        ena_n = 1'b0;
        wait_enter(4'b0010);                 // F7 digit 1
        wait_enter(4'b0010);                 // F8 digit 1
        wait_enter(4'b0100);                 // F8 digit 2
        @(posedge clk);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        wait_enter(4'b0010);                 // F9 digit 1
        cnt_tt = 8'h88;
        wait_enter(4'b0010);                 // F10 digit 1
        wait_enter(4'b1000);                 // F10 digit 3
        ena_n = 1'b1;
        repeat (6) @(negedge clk);

        tests++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL queue_drain: %0d/%0d events left, want 0/0", qa.size(), qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
